alu_4bit_core: RTL and testbench

//   Registered 4-bit ALU: add, subtract, AND, OR, XOR, unsigned greater-than, shift left, shift right.

---
 rtl/alu_4bit_pkg.sv | 17 +
 rtl/alu_4bit_if.sv | 29 ++
 rtl/alu_4bit_addsub.sv | 37 +++
 rtl/alu_4bit_core.sv | 97 +++++++++
 tb/tb_alu_4bit_core.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_4bit_pkg.sv
// Shared constants for the 4-bit registered ALU.
//   WIDTH   : operand/result width (only 4 is supported)
//   OP_*    : 3-bit opcode encodings presented on SEL
package alu_4bit_pkg;

  localparam int unsigned WIDTH = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_GT  = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_4bit_if.sv
// Bundle of the ALU operand/opcode inputs and registered result/flag outputs.
//   a, b, sel                      : operands and opcode (driven by master)
//   result, carry, overflow, zero  : registered outputs (driven by slave)
//   parity                         : even parity of result; only driven when the
//                                    core is built with ALU_PARITY_EN
// Modports: master drives operands, slave drives results.
interface alu_4bit_if;
  import alu_4bit_pkg::*;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             parity;

  modport master (
    output a, b, sel,
    input  result, carry, overflow, zero, parity
  );

  modport slave (
    input  a, b, sel,
    output result, carry, overflow, zero, parity
  );

endinterface

// File: rtl/alu_4bit_addsub.sv
// Combinational add/subtract unit for the ALU.
//   a, b   : operands
//   sub    : 0 = a+b, 1 = a-b
//   sum    : result modulo 2**WIDTH
//   carry  : carry-out for add, borrow (a<b unsigned) for subtract
//   ovf    : two's-complement overflow
module alu_4bit_addsub
  import alu_4bit_pkg::*;
#(
  parameter int unsigned W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         ovf
);

  logic [W:0] ext;

  always_comb begin
    ext = '0;
    ovf = 1'b0;
    if (sub) begin
      // Zero-extended difference: the top bit is set exactly when a borrow occurs.
      ext = {1'b0, a} - {1'b0, b};
      ovf = (a[W-1] != b[W-1]) && (ext[W-1] != a[W-1]);
    end else begin
      ext = {1'b0, a} + {1'b0, b};
      ovf = (a[W-1] == b[W-1]) && (ext[W-1] != a[W-1]);
    end
    sum   = ext[W-1:0];
    carry = ext[W];
  end

endmodule

// File: rtl/alu_4bit_core.sv
// Registered 4-bit ALU: add, sub, and, or, xor, unsigned gt, shl, shr.
// Inputs are sampled every rising clk edge; RESULT and flags appear one
// cycle later. No handshake; one operation per cycle.
//   clk       : clock
//   rst_n     : asynchronous active-low reset (RESULT=0, flags 0, ZERO=1)
//   A, B      : operands
//   SEL       : opcode (see alu_4bit_pkg)
//   RESULT    : registered result
//   CARRY     : carry / borrow / shifted-out bit
//   OVERFLOW  : two's-complement overflow for add/sub
//   ZERO      : RESULT == 0
//   PARITY    : ^RESULT, present only when ALU_PARITY_EN is defined
module alu_4bit_core
  import alu_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = alu_4bit_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       SEL,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             ZERO
`ifdef ALU_PARITY_EN
  ,
  output logic             PARITY
`endif
);

  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_ovf;

  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic             nxt_ovf;

  alu_4bit_addsub #(.W(WIDTH)) u_addsub (
    .a     (A),
    .b     (B),
    .sub   (SEL == OP_SUB),
    .sum   (as_sum),
    .carry (as_carry),
    .ovf   (as_ovf)
  );

  always_comb begin
    nxt_result = '0;
    nxt_carry  = 1'b0;
    nxt_ovf    = 1'b0;
    case (SEL)
      OP_ADD, OP_SUB: begin
        nxt_result = as_sum;
        nxt_carry  = as_carry;
        nxt_ovf    = as_ovf;
      end
      OP_AND: nxt_result = A & B;
      OP_OR:  nxt_result = A | B;
      OP_XOR: nxt_result = A ^ B;
      OP_GT:  nxt_result = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_SHL: begin
        nxt_result = {A[WIDTH-2:0], 1'b0};
        nxt_carry  = A[WIDTH-1];
      end
      OP_SHR: begin
        nxt_result = {1'b0, A[WIDTH-1:1]};
        nxt_carry  = A[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RESULT   <= '0;
      CARRY    <= 1'b0;
      OVERFLOW <= 1'b0;
      ZERO     <= 1'b1;
    end else begin
      RESULT   <= nxt_result;
      CARRY    <= nxt_carry;
      OVERFLOW <= nxt_ovf;
      ZERO     <= (nxt_result == '0);
    end
  end

`ifdef ALU_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) PARITY <= 1'b0;
    else        PARITY <= ^nxt_result;
  end
`endif

endmodule

// File: tb/tb_alu_4bit_core.sv
// Scoreboard bench for alu_4bit_core: the driver pushes model predictions
// into a queue as it issues operations; an independent monitor pops and
// compares one cycle later.
module tb_alu_4bit_core;
  import alu_4bit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_4bit_if bus ();

  alu_4bit_core #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (bus.a),
    .B        (bus.b),
    .SEL      (bus.sel),
    .RESULT   (bus.result),
    .CARRY    (bus.carry),
    .OVERFLOW (bus.overflow),
    .ZERO     (bus.zero)
`ifdef ALU_PARITY_EN
    ,
    .PARITY   (bus.parity)
`endif
  );

`ifndef ALU_PARITY_EN
  assign bus.parity = 1'b0;
`endif

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned sel;
    int unsigned r;
    bit          c;
    bit          v;
    bit          z;
    bit          p;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int to_signed4(int unsigned x);
    return (x >= 8) ? int'(x) - 16 : int'(x);
  endfunction

  // Reference model from arithmetic rules on plain integers.
  function automatic exp_t model(int unsigned a, int unsigned b, int unsigned sel);
    exp_t e;
    int   s;
    e.a = a; e.b = b; e.sel = sel;
    e.r = 0; e.c = 0; e.v = 0;
    case (sel)
      0: begin
        e.r = (a + b) % 16;
        e.c = (a + b) > 15;
        s   = to_signed4(a) + to_signed4(b);
        e.v = (s > 7) || (s < -8);
      end
      1: begin
        e.r = (a + 16 - b) % 16;
        e.c = a < b;
        s   = to_signed4(a) - to_signed4(b);
        e.v = (s > 7) || (s < -8);
      end
      2: e.r = a & b;
      3: e.r = a | b;
      4: e.r = a ^ b;
      5: e.r = (a > b) ? 1 : 0;
      6: begin e.r = (a * 2) % 16; e.c = a >= 8; end
      default: begin e.r = a / 2; e.c = a % 2; end
    endcase
    e.z = (e.r == 0);
    e.p = $countones(e.r) % 2;
    return e;
  endfunction

  task automatic issue(int unsigned a, int unsigned b, int unsigned sel);
    @(negedge clk);
    bus.a   = a[3:0];
    bus.b   = b[3:0];
    bus.sel = sel[2:0];
    q.push_back(model(a, b, sel));
  endtask

  task automatic check_reset(string name);
    checks++;
    if (bus.result !== 4'd0 || bus.carry !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.zero !== 1'b1
`ifdef ALU_PARITY_EN
        || bus.parity !== 1'b0
`endif
       ) begin
      errors++;
      $display("FAIL %s: got R=%b C=%b V=%b Z=%b P=%b, want R=0000 C=0 V=0 Z=1 P=0",
               name, bus.result, bus.carry, bus.overflow, bus.zero, bus.parity);
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected results never observed, want 0", name, q.size());
      q.delete();
    end
  endtask

  // Monitor: outputs after each rising edge reflect the oldest issued operation.
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && q.size() != 0) begin
        e = q.pop_front();
        checks++;
        bad = (bus.result !== e.r[3:0]) || (bus.carry !== e.c) ||
              (bus.overflow !== e.v) || (bus.zero !== e.z);
`ifdef ALU_PARITY_EN
        bad = bad || (bus.parity !== e.p);
`endif
        if (bad) begin
          errors++;
          $display("FAIL op sel=%03b a=%04b b=%04b: got R=%04b C=%b V=%b Z=%b P=%b, want R=%04b C=%b V=%b Z=%b P=%b",
                   e.sel[2:0], e.a[3:0], e.b[3:0], bus.result, bus.carry, bus.overflow,
                   bus.zero, bus.parity, e.r[3:0], e.c, e.v, e.z, e.p);
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    bus.a   = 4'hF;
    bus.b   = 4'h1;
    bus.sel = 3'b000;
    #12;
    check_reset("reset_initial");
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(4'b0011, 4'b0001, 0);
    issue(4'b0111, 4'b0001, 0);
    issue(4'b1111, 4'b0001, 0);
    issue(4'b0110, 4'b0011, 1);
    issue(4'b0001, 4'b0010, 1);
    issue(4'b1000, 4'b0001, 1);
    issue(4'b1100, 4'b1010, 2);
    issue(4'b1100, 4'b1010, 3);
    issue(4'b1100, 4'b1010, 4);
    issue(4'b1100, 4'b0011, 2);
    issue(4'b0100, 4'b0011, 5);
    issue(4'b0011, 4'b0100, 5);
    issue(4'b0101, 4'b0101, 5);
    issue(4'b1010, 4'b0000, 6);
    issue(4'b1000, 4'b0000, 7);
    issue(4'b0001, 4'b0000, 7);
    issue(4'b0000, 4'b0000, 1);
    issue(4'b1000, 4'b1000, 0);

    // Back-to-back: every opcode in consecutive cycles
    for (int unsigned op = 0; op < 8; op++)
      issue($urandom_range(15), $urandom_range(15), op);

    // Randomized
    for (int i = 0; i < 300; i++)
      issue($urandom_range(15), $urandom_range(15), $urandom_range(7));
    drain("drain_random");

    // Mid-cycle asynchronous reset after a nonzero result
    issue(4'b0011, 4'b0001, 0);
    drain("drain_pre_reset");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("reset_midcycle");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      issue($urandom_range(15), $urandom_range(15), $urandom_range(7));
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
